// File: rtl/trivium_pkg.sv
// Shared constants and types for the Trivium keystream generator.
//   - Widths of key, IV and the 288-bit internal state.
//   - Tap positions in the algorithm's 1-based numbering (s1..s288).
//     State bit sN is stored at vector index N-1.
//   - FSM state encoding and the default warm-up length.
package trivium_pkg;

    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;
    localparam int STATE_W = 288;
    localparam int CNT_W   = 11;

    localparam int WARMUP_ROUNDS_DEF = 1152;

    // Tap positions, 1-based as in the algorithm description.
    localparam int S066 = 66;
    localparam int S069 = 69;
    localparam int S091 = 91;
    localparam int S092 = 92;
    localparam int S093 = 93;
    localparam int S162 = 162;
    localparam int S171 = 171;
    localparam int S175 = 175;
    localparam int S176 = 176;
    localparam int S177 = 177;
    localparam int S243 = 243;
    localparam int S264 = 264;
    localparam int S286 = 286;
    localparam int S287 = 287;
    localparam int S288 = 288;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_RUN    = 2'd3
    } fsm_e;

endpackage

// File: rtl/trivium_round8.sv
// Eight Trivium rounds unrolled as pure combinational logic.
// Ports:
//   state_i [287:0] : current state, s1 at bit 0
//   state_o [287:0] : state after eight rounds
//   z_o     [7:0]   : keystream bits; z_o[r] is the output of round r
module trivium_round8
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    output logic [STATE_W-1:0] state_o,
    output logic [7:0]         z_o
);

    logic [STATE_W-1:0] s;
    logic               t1;
    logic               t2;
    logic               t3;

    always_comb begin
        s  = state_i;
        z_o = '0;
        t1 = 1'b0;
        t2 = 1'b0;
        t3 = 1'b0;
        for (int r = 0; r < 8; r++) begin
            t1 = s[S066-1] ^ s[S093-1];
            t2 = s[S162-1] ^ s[S177-1];
            t3 = s[S243-1] ^ s[S288-1];
            z_o[r] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[S091-1] & s[S092-1]) ^ s[S171-1];
            t2 = t2 ^ (s[S175-1] & s[S176-1]) ^ s[S264-1];
            t3 = t3 ^ (s[S286-1] & s[S287-1]) ^ s[S069-1];
            // Three shift registers: s1..s93 fed by t3, s94..s177 by t1,
            // s178..s288 by t2; the last bit of each register falls off.
            s = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        state_o = s;
    end

endmodule

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator producing one keystream byte per cycle.
// After a load it runs WARMUP_ROUNDS rounds (8 per cycle), then presents
// bytes on a registered valid/ready interface.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   enable           : global advance gate; 0 freezes everything (load too)
//   key [79:0]       : key, K1 = key[0]
//   iv  [79:0]       : IV, IV1 = iv[0]
//   load             : strobe, samples key/iv and restarts initialisation
//   ks_byte [7:0]    : keystream byte, bit 0 generated first
//   ks_valid         : ks_byte holds an unconsumed byte
//   ks_ready         : consumer takes ks_byte when ks_valid && ks_ready
//   busy             : high from load until the first byte is presented
module trivium_keystream_gen
    import trivium_pkg::*;
#(
    parameter int WARMUP_ROUNDS = WARMUP_ROUNDS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    input  logic             load,
    output logic [7:0]       ks_byte,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] WARMUP_CNT = CNT_W'(WARMUP_ROUNDS);
    localparam logic [CNT_W-1:0] STEP_CNT   = CNT_W'(8);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    fsm_e               fsm_q, fsm_d;
    logic [7:0]         byte_q, byte_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [STATE_W-1:0] step_state;
    logic [7:0]         step_z;
    logic [STATE_W-1:0] load_state;

    trivium_round8 u_round8 (
        .state_i (state_q),
        .state_o (step_state),
        .z_o     (step_z)
    );

    // s1..s80 = key, s94..s173 = iv, s286..s288 = 1, everything else 0.
    assign load_state = {3'b111, 112'b0, iv, 13'b0, key};
    assign cnt_inc    = cnt_q + STEP_CNT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fsm_d   = fsm_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        if (enable) begin
            if (load) begin
                // Restart from any state; a pending byte is dropped.
                state_d = load_state;
                cnt_d   = '0;
                fsm_d   = ST_WARMUP;
                valid_d = 1'b0;
                busy_d  = 1'b1;
            end else begin
                case (fsm_q)
                    ST_IDLE: begin
                    end
                    ST_WARMUP: begin
                        state_d = step_state;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == WARMUP_CNT) begin
                            fsm_d = ST_FILL;
                        end
                    end
                    ST_FILL: begin
                        state_d = step_state;
                        byte_d  = step_z;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        fsm_d   = ST_RUN;
                    end
                    ST_RUN: begin
                        // Refill in the same cycle as the handshake: no bubble.
                        if (valid_q && ks_ready) begin
                            state_d = step_state;
                            byte_d  = step_z;
                        end
                    end
                    default: begin
                        fsm_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            cnt_q   <= '0;
            fsm_q   <= ST_IDLE;
            byte_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fsm_q   <= fsm_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign ks_byte  = byte_q;
    assign ks_valid = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
module tb_trivium_keystream_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [79:0] key;
    logic [79:0] iv;
    logic        load;
    logic [7:0]  ks_byte;
    logic        ks_valid;
    logic        ks_ready;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          e0_cyc = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_q[$];
    bit [288:1]  gs;

    localparam logic [79:0] K2 = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] V2 = 80'hFEDCBA9876543210FEDC;
    localparam logic [79:0] K4 = 80'h13579BDF02468ACE1122;
    localparam logic [79:0] V4 = 80'h00FF00FF00FF00FF00FF;
    localparam logic [79:0] K5 = 80'hA5A5A5A5A5A5A5A5A5A5;
    localparam logic [79:0] V5 = 80'h5A5A5A5A5A5A5A5A5A5A;

    trivium_keystream_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .key      (key),
        .iv       (iv),
        .load     (load),
        .ks_byte  (ks_byte),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bit-serial reference: one round on gs, s1 at gs[1].
    task automatic model_round(output bit z);
        bit t1, t2, t3;
        t1 = gs[66] ^ gs[93];
        t2 = gs[162] ^ gs[177];
        t3 = gs[243] ^ gs[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (gs[91] & gs[92]) ^ gs[171];
        t2 = t2 ^ (gs[175] & gs[176]) ^ gs[264];
        t3 = t3 ^ (gs[286] & gs[287]) ^ gs[69];
        for (int k = 288; k >= 2; k--) begin
            if (k != 94 && k != 178) gs[k] = gs[k-1];
        end
        gs[1]   = t3;
        gs[94]  = t1;
        gs[178] = t2;
    endtask

    task automatic model_push(input logic [79:0] k, input logic [79:0] v, input int n);
        bit z;
        logic [7:0] b;
        gs = '0;
        for (int i = 1; i <= 80; i++) gs[i] = k[i-1];
        for (int i = 1; i <= 80; i++) gs[93+i] = v[i-1];
        gs[286] = 1'b1;
        gs[287] = 1'b1;
        gs[288] = 1'b1;
        for (int i = 0; i < 1152; i++) model_round(z);
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < 8; i++) begin
                model_round(z);
                b[i] = z;
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load with optional simultaneous ready; ready is dropped after the load edge.
    task automatic do_load(input logic [79:0] k, input logic [79:0] v, input int n, input logic rdy);
        exp_q.delete();
        model_push(k, v, n);
        key = k;
        iv = v;
        load = 1'b1;
        ks_ready = rdy;
        tick();
        load = 1'b0;
        ks_ready = 1'b0;
        e0_cyc = cyc;
        check_val("load_valid", ks_valid, 0);
        check_val("load_busy", busy, 1);
    endtask

    task automatic wait_valid(input int exp_lat);
        int lat;
        for (int i = 0; i < 400 && !ks_valid; i++) tick();
        lat = cyc - e0_cyc;
        check_val("first_valid_latency", lat, exp_lat);
        check_val("busy_after_fill", busy, 0);
    endtask

    task automatic drain(input bit rnd, input int pause_at, input int pause_len, input int exp_cycles);
        int it;
        it = 0;
        while (exp_q.size() > 0 && it < 3000) begin
            if (it == pause_at) enable = 1'b0;
            if (it == pause_at + pause_len) enable = 1'b1;
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            it++;
        end
        enable = 1'b1;
        ks_ready = 1'b0;
        check_val("sb_drained", exp_q.size(), 0);
        if (exp_cycles >= 0) check_val("drain_cycles", it, exp_cycles);
    endtask

    // Scoreboard monitor: compares each accepted byte and checks hold stability.
    initial begin : monitor
        bit         hold_pend;
        logic [7:0] hold_byte;
        hold_pend = 1'b0;
        hold_byte = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (hold_pend && ks_valid) check_val("hold_stable", ks_byte, hold_byte);
                if (ks_valid && ks_ready && enable && !load) begin
                    check_val("sb_underrun", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check_val("ks_byte", ks_byte, exp_q.pop_front());
                end
                hold_pend = ks_valid && !(ks_ready && enable && !load);
                hold_byte = ks_byte;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        enable = 1'b1;
        key = '0;
        iv = '0;
        load = 1'b0;
        ks_ready = 1'b0;
        #2;
        check_val("rst_valid", ks_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_byte", ks_byte, 0);
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset: nothing happens without a load.
        for (int i = 0; i < 200; i++) begin
            tick();
            check_val("idle_valid", ks_valid, 0);
            check_val("idle_busy", busy, 0);
            check_val("idle_byte", ks_byte, 0);
        end
        mon_en = 1'b1;

        // Zero key/iv, continuous ready.
        do_load('0, '0, 64, 1'b0);
        wait_valid(145);
        drain(1'b0, -1, 0, 64);

        // Non-trivial key/iv: full-rate and then random back-pressure.
        do_load(K2, V2, 48, 1'b0);
        wait_valid(145);
        drain(1'b0, -1, 0, 48);
        do_load(K2, V2, 48, 1'b0);
        wait_valid(145);
        drain(1'b1, -1, 0, -1);

        // Reload mid-warm-up, then reload in RUN together with a handshake.
        do_load(K5, V5, 0, 1'b0);
        repeat (70) tick();
        check_val("warm_valid", ks_valid, 0);
        check_val("warm_busy", busy, 1);
        do_load(K4, V4, 10, 1'b0);
        wait_valid(145);
        drain(1'b0, -1, 0, 10);
        do_load(K2, V2, 16, 1'b1);
        wait_valid(145);
        drain(1'b0, -1, 0, 16);

        // Enable gating in warm-up (with an ignored load) and in RUN.
        do_load(K4, V4, 24, 1'b0);
        repeat (50) tick();
        enable = 1'b0;
        repeat (5) tick();
        key = K5;
        iv = V5;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (14) tick();
        check_val("gated_busy", busy, 1);
        enable = 1'b1;
        wait_valid(165);
        drain(1'b0, 8, 5, 29);

        // Asynchronous reset in the middle of RUN.
        do_load(K2, V2, 300, 1'b0);
        wait_valid(145);
        ks_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", ks_valid, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_byte", ks_byte, 0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("post_rst_valid", ks_valid, 0);
            check_val("post_rst_busy", busy, 0);
        end
        ks_ready = 1'b0;
        mon_en = 1'b1;
        do_load(K5, V5, 8, 1'b0);
        wait_valid(145);
        drain(1'b0, -1, 0, 8);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
